// File: rtl/maxmin_pkg.sv
// Shared definitions for the max/min peak-capture path.
// Holds the buffer size defaults, the lane geometry, the FSM encoding, the
// read-word field layout and the 8-bit unsigned max/min helper functions.
package maxmin_pkg;
  localparam int DEPTH_DEF = 1024;
  localparam int AW_DEF    = 10;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int PAIR_W = 2 * LANE_W;

  // rd_data / RAM word layout: {max, min}
  localparam int RD_MAX_MSB = 15;
  localparam int RD_MAX_LSB = 8;
  localparam int RD_MIN_MSB = 7;
  localparam int RD_MIN_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [LANE_W-1:0] umax(input logic [LANE_W-1:0] a,
                                             input logic [LANE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [LANE_W-1:0] umin(input logic [LANE_W-1:0] a,
                                             input logic [LANE_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/peak_ram.sv
// Simple dual-port capture RAM, DEPTH x DW.
// Ports: clk; rst (async, clears only the read register); we/wa/wd write
// port; ra address and rd registered read data (1-cycle latency).
// A read of the address being written in the same cycle returns old data.
module peak_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];

  // Array itself carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd <= '0;
    else     rd <= mem[ra];
  end
endmodule

// File: rtl/maxmin_capture.sv
// Peak-detect capture stage behind the four-lane max/min detector.
// Reduces four lane maxima/minima to one pair on each en_in pulse and stores
// the pairs in a capture buffer under an IDLE/FILL/DONE state machine.
// Ports: clk, rst (async high); en_in, max_in, min_in from the detector;
// start/abort control pulses; busy/done/wr_count status; rd_addr/rd_data
// host read port (registered, 1-cycle latency).
module maxmin_capture
  import maxmin_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic [LANES*LANE_W-1:0] max_in,
  input  logic [LANES*LANE_W-1:0] min_in,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [AW:0]            wr_count,
  input  logic [AW-1:0]          rd_addr,
  output logic [PAIR_W-1:0]      rd_data
);
  logic [1:0]                   state;
  logic [LANES-1:0][LANE_W-1:0] mx_l, mn_l;
  logic [LANE_W-1:0]            max_red, min_red;
  logic [LANE_W-1:0]            max4, min4;
  logic                         wv;
  logic [AW-1:0]                wr_addr;
  logic                         last;
  logic                         we;
  logic [PAIR_W-1:0]            wd;

  assign mx_l = max_in;
  assign mn_l = min_in;

  // Two-level compare tree per output, no intermediate register.
  assign max_red = umax(umax(mx_l[0], mx_l[1]), umax(mx_l[2], mx_l[3]));
  assign min_red = umin(umin(mn_l[0], mn_l[1]), umin(mn_l[2], mn_l[3]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max4 <= '0;
      min4 <= '0;
      wv   <= 1'b0;
    end else begin
      if (en_in) begin
        max4 <= max_red;
        min4 <= min_red;
      end
      wv <= en_in & (state == ST_FILL);
    end
  end

  assign last = (wr_addr == AW'(DEPTH - 1));

  // A pending pair is dropped by abort or restart, except that the final
  // (DEPTH-1) write still lands when it coincides with abort.
  assign we = wv & (state == ST_FILL) & (abort ? last : ~start);

  always_comb begin
    wd = '0;
    wd[RD_MAX_MSB:RD_MAX_LSB] = max4;
    wd[RD_MIN_MSB:RD_MIN_LSB] = min4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_addr  <= '0;
      wr_count <= '0;
    end else begin
      if (we) begin
        if (!last) wr_addr <= wr_addr + 1'b1;
        if (wr_count != (AW+1)'(DEPTH)) wr_count <= wr_count + 1'b1;
      end
      if (abort) begin
        state <= ST_IDLE;
      end else if (start) begin
        state    <= ST_FILL;
        wr_addr  <= '0;
        wr_count <= '0;
      end else if (we && last) begin
        state <= ST_DONE;
      end
    end
  end

  assign busy = (state == ST_FILL);
  assign done = (state == ST_DONE);

  peak_ram #(.DEPTH(DEPTH), .AW(AW), .DW(PAIR_W)) u_ram (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wr_addr),
    .wd  (wd),
    .ra  (rd_addr),
    .rd  (rd_data)
  );
endmodule

// File: tb/tb_maxmin_capture.sv
module tb_maxmin_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_in = 1'b0;
  logic [31:0] max_in = '0;
  logic [31:0] min_in = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [10:0] wr_count;
  logic [9:0]  rd_addr = '0;
  logic [15:0] rd_data;

  int errors = 0;
  int checks = 0;

  maxmin_capture #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .max_in(max_in), .min_in(min_in),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .wr_count(wr_count), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [15:0] exp);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(wr_count), 0);
    chk("rst_rd", 32'(rd_data), 0);
    tick();
    rst = 1'b0;
    tick();

    // reduce: one pulse, check latency and reduced pair
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    en_in = 1'b1; max_in = 32'h10F07F80; min_in = 32'h0501FF02;
    tick();
    en_in = 1'b0;
    chk("red_cnt_t1", 32'(wr_count), 0);
    tick();
    chk("red_cnt_t2", 32'(wr_count), 1);
    rd("red_rd0", 10'd0, 16'hF001);

    // fill: DEPTH back-to-back pulses
    pulse_start();
    min_in = '0;
    for (int i = 0; i < 1024; i++) begin
      en_in = 1'b1; max_in = {24'h0, 8'(i)};
      tick();
    end
    en_in = 1'b0;
    chk("fill_pre_done", 32'(done), 0);
    chk("fill_pre_busy", 32'(busy), 1);
    chk("fill_pre_cnt", 32'(wr_count), 1023);
    tick();
    chk("fill_done", 32'(done), 1);
    chk("fill_busy", 32'(busy), 0);
    chk("fill_cnt", 32'(wr_count), 1024);
    en_in = 1'b1; max_in = 32'h000000AA; min_in = 32'hAAAAAAAA;
    tick();
    en_in = 1'b0;
    tick(); tick();
    chk("fill_extra_cnt", 32'(wr_count), 1024);
    chk("fill_extra_done", 32'(done), 1);
    rd("fill_rd0", 10'd0, 16'h0000);
    rd("fill_rd1", 10'd1, 16'h0100);
    rd("fill_rd255", 10'd255, 16'hFF00);
    rd("fill_rd256", 10'd256, 16'h0000);
    rd("fill_rd1023", 10'd1023, 16'hFF00);
    rd("fill_rd517", 10'd517, 16'h0500);

    // abort coinciding with 6th pulse
    pulse_start();
    chk("abort_done_clr", 32'(done), 0);
    for (int k = 0; k < 5; k++) begin
      en_in = 1'b1; max_in = {24'h0, 8'(8'h50 + k)}; min_in = {4{8'(k + 1)}};
      tick();
      en_in = 1'b0;
      tick();
    end
    en_in = 1'b1; abort = 1'b1; max_in = 32'h000000EE; min_in = 32'hEEEEEEEE;
    tick();
    en_in = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_cnt", 32'(wr_count), 5);
    rd("abort_rd0", 10'd0, 16'h5001);
    rd("abort_rd4", 10'd4, 16'h5405);
    rd("abort_rd5", 10'd5, 16'h0500);

    // restart mid-capture
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      en_in = 1'b1; max_in = {24'h0, 8'(8'h30 + i)}; min_in = {4{8'(8'h40 + i)}};
      tick();
    end
    en_in = 1'b0;
    tick();
    chk("rs_cnt10", 32'(wr_count), 10);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      en_in = 1'b1; max_in = {24'h0, 8'(8'hC0 + i)}; min_in = {4{8'(8'hD0 + i)}};
      tick();
    end
    en_in = 1'b0;
    tick();
    chk("rs_cnt3", 32'(wr_count), 3);
    chk("rs_busy", 32'(busy), 1);
    rd("rs_rd0", 10'd0, 16'hC0D0);
    rd("rs_rd2", 10'd2, 16'hC2D2);
    rd("rs_rd3", 10'd3, 16'h3343);
    rd("rs_rd9", 10'd9, 16'h3949);
    pulse_abort();

    // start and en_in in the same cycle from IDLE
    start = 1'b1; en_in = 1'b1; max_in = 32'h000000EE; min_in = 32'h11111111;
    tick();
    start = 1'b0; en_in = 1'b0;
    tick(); tick();
    chk("sc_cnt0", 32'(wr_count), 0);
    chk("sc_busy", 32'(busy), 1);
    rd("sc_rd0_old", 10'd0, 16'hC0D0);
    en_in = 1'b1; max_in = 32'h00000077; min_in = 32'h66666666;
    tick();
    en_in = 1'b0;
    tick();
    chk("sc_cnt1", 32'(wr_count), 1);
    rd("sc_rd0_new", 10'd0, 16'h7766);

    // reset mid-FILL
    pulse_abort();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      en_in = 1'b1; max_in = {24'h0, 8'(8'h90 + i)}; min_in = 32'h11111111;
      tick();
    end
    en_in = 1'b0;
    tick();
    chk("mr_cnt7", 32'(wr_count), 7);
    rd("mr_rd0", 10'd0, 16'h9011);
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_cnt", 32'(wr_count), 0);
    chk("mr_rd", 32'(rd_data), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_idle_busy", 32'(busy), 0);
    chk("mr_idle_done", 32'(done), 0);
    en_in = 1'b1; max_in = 32'h000000AB; min_in = 32'hCDCDCDCD;
    tick();
    en_in = 1'b0;
    tick(); tick();
    chk("mr_idle_cnt", 32'(wr_count), 0);
    rd("mr_rd0_kept", 10'd0, 16'h9011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
